// File: rtl/uart_tx_if.sv
// Byte handshake between the producer and the UART transmitter.
// The producer drives DIN/DIN_VLD; the transmitter answers with DIN_RDY.
interface uart_tx_if;
  logic [7:0] DIN;
  logic       DIN_VLD;
  logic       DIN_RDY;

  modport master (
    output DIN,
    output DIN_VLD,
    input  DIN_RDY
  );

  modport slave (
    input  DIN,
    input  DIN_VLD,
    output DIN_RDY
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB-first, optional parity,
// 1 or 2 stop bits; zero-gap back-to-back frames via stop-bit handshake.
module uart_tx #(
  parameter int    CLK_DIV_VAL = 434,
  parameter string PARITY_BIT  = "none",
  parameter int    STOP_BITS   = 1
) (
  input  logic      CLK,
  input  logic      RST_N,
  uart_tx_if.slave  din_if,
  output logic      UART_TXD,
  output logic      BUSY
);

  localparam bit P_EVEN  = (PARITY_BIT == "even");
  localparam bit P_ODD   = (PARITY_BIT == "odd");
  localparam bit P_MARK  = (PARITY_BIT == "mark");
  localparam bit P_SPACE = (PARITY_BIT == "space");
  localparam bit PAR_EN  = P_EVEN | P_ODD | P_MARK | P_SPACE;

  localparam logic        STOP_LAST = (STOP_BITS == 2);
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV_VAL - 1);

  typedef enum logic [2:0] {
    IDLE,
    STARTBIT,
    DATABITS,
    PARITYBIT,
    STOPBIT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic        stop_q, stop_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;

  logic div_last;
  logic din_rdy;
  logic hs;

  assign div_last = (div_q == DIV_LAST);

  // Ready in the very last cycle of the final stop bit too
  assign din_rdy = RST_N & ((state_q == IDLE) |
                   ((state_q == STOPBIT) & div_last &
                    (stop_q == STOP_LAST)));

  assign hs             = din_if.DIN_VLD & din_rdy;
  assign din_if.DIN_RDY = din_rdy;
  assign UART_TXD       = txd_q;
  assign BUSY           = busy_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = 1'b1;
    busy_d  = 1'b0;

    if (state_q != IDLE) begin
      div_d = div_last ? 16'd0 : div_q + 16'd1;
    end

    unique case (state_q)
      IDLE: begin
      end
      STARTBIT: begin
        if (div_last) begin
          state_d = DATABITS;
          bit_d   = 3'd0;
        end
      end
      DATABITS: begin
        if (div_last) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = PAR_EN ? PARITYBIT : STOPBIT;
            stop_d  = 1'b0;
          end
        end
      end
      PARITYBIT: begin
        if (div_last) begin
          state_d = STOPBIT;
          stop_d  = 1'b0;
        end
      end
      STOPBIT: begin
        if (div_last) begin
          if (stop_q == STOP_LAST) state_d = IDLE;
          else stop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (hs) begin
      state_d = STARTBIT;
      div_d   = 16'd0;
      shift_d = din_if.DIN;
      par_d   = P_EVEN ? ^din_if.DIN :
                P_ODD  ? ~^din_if.DIN : P_MARK;
    end

    unique case (state_d)
      STARTBIT:  txd_d = 1'b0;
      DATABITS:  txd_d = shift_d[0];
      PARITYBIT: txd_d = par_d;
      default:   txd_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: five instances at CLK_DIV_VAL=4 cover
// none/even/odd/mark parity and space parity with two stop bits.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] din = 8'h00;
  logic [4:0] vld = 5'b0;
  logic [4:0] txd;
  logic [4:0] busy;
  logic [4:0] rdy;
  int         checks = 0;
  int         failures = 0;

  always #5 CLK = ~CLK;

  uart_tx_if if0 ();
  uart_tx_if if1 ();
  uart_tx_if if2 ();
  uart_tx_if if3 ();
  uart_tx_if if4 ();

  assign if0.DIN = din;
  assign if1.DIN = din;
  assign if2.DIN = din;
  assign if3.DIN = din;
  assign if4.DIN = din;
  assign if0.DIN_VLD = vld[0];
  assign if1.DIN_VLD = vld[1];
  assign if2.DIN_VLD = vld[2];
  assign if3.DIN_VLD = vld[3];
  assign if4.DIN_VLD = vld[4];
  assign rdy = {if4.DIN_RDY, if3.DIN_RDY, if2.DIN_RDY,
                if1.DIN_RDY, if0.DIN_RDY};

  uart_tx #(.CLK_DIV_VAL(4), .PARITY_BIT("none"), .STOP_BITS(1)) u0 (
    .CLK(CLK), .RST_N(RST_N), .din_if(if0),
    .UART_TXD(txd[0]), .BUSY(busy[0]));
  uart_tx #(.CLK_DIV_VAL(4), .PARITY_BIT("even"), .STOP_BITS(1)) u1 (
    .CLK(CLK), .RST_N(RST_N), .din_if(if1),
    .UART_TXD(txd[1]), .BUSY(busy[1]));
  uart_tx #(.CLK_DIV_VAL(4), .PARITY_BIT("odd"), .STOP_BITS(1)) u2 (
    .CLK(CLK), .RST_N(RST_N), .din_if(if2),
    .UART_TXD(txd[2]), .BUSY(busy[2]));
  uart_tx #(.CLK_DIV_VAL(4), .PARITY_BIT("mark"), .STOP_BITS(1)) u3 (
    .CLK(CLK), .RST_N(RST_N), .din_if(if3),
    .UART_TXD(txd[3]), .BUSY(busy[3]));
  uart_tx #(.CLK_DIV_VAL(4), .PARITY_BIT("space"), .STOP_BITS(2)) u4 (
    .CLK(CLK), .RST_N(RST_N), .din_if(if4),
    .UART_TXD(txd[4]), .BUSY(busy[4]));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Start sampling right after the handshake edge; level l of the frame
  // is exp[l]. Optionally raises DIN_VLD with byte nb at cycle raise_at.
  task automatic watch(input int idx, input int n,
                       input logic [11:0] exp, input string tag,
                       input int raise_at, input logic [7:0] nb);
    int bad;
    int cyc;
    logic rdy_exp;
    cyc = 0;
    for (int l = 0; l < n; l++) begin
      bad = 0;
      for (int c = 0; c < 4; c++) begin
        if (cyc == raise_at) begin
          din = nb;
          vld[idx] = 1'b1;
        end
        rdy_exp = (l == n - 1) && (c == 3);
        if (txd[idx] !== exp[l] || busy[idx] !== 1'b1 ||
            rdy[idx] !== rdy_exp) bad++;
        cyc++;
        tick();
      end
      chk($sformatf("%s_lvl%0d_badcycles", tag, l), bad, 0);
    end
  endtask

  task automatic idle_chk(input int idx, input string tag);
    chk({tag, "_txd"}, {31'b0, txd[idx]}, 1);
    chk({tag, "_busy"}, {31'b0, busy[idx]}, 0);
    chk({tag, "_rdy"}, {31'b0, rdy[idx]}, 1);
  endtask

  task automatic send(input int idx, input logic [7:0] b);
    din = b;
    vld[idx] = 1'b1;
    tick();
    vld[idx] = 1'b0;
  endtask

  initial begin
    int bad;

    RST_N = 1'b0;
    repeat (5) tick();
    chk("rst_txd", {27'b0, txd}, 32'h1f);
    chk("rst_busy", {27'b0, busy}, 32'h0);
    chk("rst_rdy", {27'b0, rdy}, 32'h0);

    RST_N = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (txd !== 5'h1f || busy !== 5'h0 || rdy !== 5'h1f) bad++;
    end
    chk("idle100_badcycles", bad, 0);

    send(0, 8'hA5);
    watch(0, 10, 12'h34A, "a5", -1, 8'h00);
    idle_chk(0, "a5_end");

    send(1, 8'h03);
    watch(1, 11, 12'h406, "even03", -1, 8'h00);
    idle_chk(1, "even03_end");

    send(2, 8'h03);
    watch(2, 11, 12'h606, "odd03", -1, 8'h00);
    idle_chk(2, "odd03_end");

    send(3, 8'h03);
    watch(3, 11, 12'h606, "mark03", -1, 8'h00);
    idle_chk(3, "mark03_end");

    din = 8'h55;
    vld[0] = 1'b1;
    tick();
    din = 8'hAA;
    watch(0, 10, 12'h2AA, "b2b55", -1, 8'h00);
    vld[0] = 1'b0;
    watch(0, 10, 12'h354, "b2bAA", -1, 8'h00);
    idle_chk(0, "b2b_end");

    send(4, 8'h03);
    watch(4, 12, 12'hC06, "bp03", 10, 8'hF0);
    vld[4] = 1'b0;
    watch(4, 12, 12'hDE0, "bpF0", -1, 8'h00);
    idle_chk(4, "bp_end");

    send(0, 8'hA5);
    repeat (18) tick();
    chk("prerst_txd", {31'b0, txd[0]}, 0);
    #2;
    RST_N = 1'b0;
    #1;
    chk("midrst_txd", {31'b0, txd[0]}, 1);
    chk("midrst_busy", {31'b0, busy[0]}, 0);
    chk("midrst_rdy", {31'b0, rdy[0]}, 0);
    tick();
    tick();
    RST_N = 1'b1;
    send(0, 8'h0F);
    watch(0, 10, 12'h21E, "rst0f", -1, 8'h00);
    idle_chk(0, "rst0f_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter. It is the transmit-side companion of the team's UART receiver and uses the same frame format and parity options.
- Accepts one byte at a time over a valid/ready handshake, then serializes it LSB-first onto UART_TXD.
- Frame: start bit, 8 data bits, optional parity bit, 1 or 2 stop bits.
- Sits between the user logic/FIFO and the FPGA TX pin, and loops back to the receiver in system tests.

Parameters:
- CLK_DIV_VAL, 434: CLK cycles per serial bit (434 = 115200 baud at 50 MHz). Legal range 2..65535.
- PARITY_BIT, "none": one of "none", "even", "odd", "mark", "space". Any other value behaves as "none".
- STOP_BITS, 1: number of stop bits, 1 or 2. Any other value behaves as 1.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST_N  input  1  reset, asynchronous and active-low.
- DIN  input  8  byte to transmit; sampled only on handshake.
- DIN_VLD  input  1  DIN holds a valid byte.
- DIN_RDY  output  1  transmitter can accept a byte this cycle.
- UART_TXD  output  1  serial transmit line, idle high, registered.
- BUSY  output  1  a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (RST_N low, asynchronous):
  - UART_TXD=1, BUSY=0, DIN_RDY=0 while reset is held.
  - FSM goes to IDLE; bit, stop and divider counters clear; shift register is cleared.
  - Reset in mid-frame aborts the frame at once: TXD returns high and the byte is discarded.
  - The first byte can be accepted on the first CLK edge after RST_N rises.
- Handshake:
  - A byte transfers on a rising edge where DIN_VLD=1 and DIN_RDY=1.
  - DIN_RDY=1 in IDLE.
  - DIN_RDY=1 also in the last CLK cycle of the final stop bit (divider = CLK_DIV_VAL-1), to allow zero-gap back-to-back frames. It is 0 at all other times.
  - DIN_VLD while DIN_RDY=0 has no effect; the byte is not captured.
- Bit timing:
  - A 16-bit divider restarts at 0 on every handshake.
  - Every bit lasts exactly CLK_DIV_VAL cycles. The divider wraps at CLK_DIV_VAL-1, and each wrap advances the bit.
  - The divider does not run freely in IDLE.
- FSM states: IDLE, STARTBIT, DATABITS, PARITYBIT, STOPBIT.
  - IDLE: TXD=1. On handshake, latch DIN and compute parity, then go to STARTBIT. TXD=0 is visible the cycle after the handshake edge.
  - STARTBIT: TXD=0 for one bit time, then DATABITS.
  - DATABITS: TXD = shift[0]; shift right on each bit boundary. A 3-bit counter 0..7 advances per bit. After bit 7, go to PARITYBIT, or to STOPBIT when PARITY_BIT is "none".
  - PARITYBIT: TXD = parity for one bit time, then STOPBIT.
    - even: XOR of DIN.
    - odd: inverted XOR of DIN.
    - mark: 1.
    - space: 0.
  - STOPBIT: TXD=1 for STOP_BITS bit times. On the final boundary:
    - if a handshake occurs on that edge, go to STARTBIT (next start bit begins with no idle gap);
    - otherwise go to IDLE.
- Frame length: (10 + P + STOP_BITS - 1) × CLK_DIV_VAL cycles, where P=1 if parity is enabled, else 0.
- BUSY is registered and goes to 1 the cycle after the handshake. It stays 1 through continuous back-to-back frames and falls on the cycle TXD enters IDLE.
- UART_TXD is driven only from a register, so it is glitch-free.

Test Plan:
- Reset/idle: hold RST_N low 5 cycles, then release with DIN_VLD=0 -> UART_TXD=1, BUSY=0, DIN_RDY=1; no change for 100 cycles.
- Single byte, CLK_DIV_VAL=4, parity none, STOP_BITS=1: send 0xA5 -> TXD sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first, stop); each level lasts exactly 4 cycles; frame is 40 cycles; BUSY is high for 40 cycles.
- Parity: send 0x03 with even parity -> parity bit 0; with odd -> 1; mark -> 1; space -> 0. Frame is 44 cycles with CLK_DIV_VAL=4. Loopback into the receiver with the same settings gives DOUT=0x03 and no PARITY_ERROR.
- Back-to-back: hold DIN_VLD=1 and present 0x55 then 0xAA -> second start bit immediately follows the first stop bit with zero idle cycles; DIN_RDY pulses for 1 cycle at the frame end; BUSY stays 1 throughout.
- Two stop bits with backpressure: STOP_BITS=2; assert DIN_VLD mid-frame -> DIN not captured until DIN_RDY; the stop level lasts 2×CLK_DIV_VAL cycles.
- Reset mid-frame: drop RST_N during data bit 3 -> TXD=1 asynchronously (before the next CLK edge). After release, a new byte 0x0F transmits correctly from a fresh start bit.
